// File: rtl/decoder_4x16_if.sv
// Select/enable bus into the 4-to-16 decoder and its decoded line outputs.
// The address side uses the master modport, the decoder the slave modport.
interface decoder_4x16_if;
    logic        en;
    logic        w;
    logic        a;
    logic        b;
    logic        c;
    logic [15:0] d;
    logic        d_valid;

    modport master (
        output en,
        output w,
        output a,
        output b,
        output c,
        input  d,
        input  d_valid
    );

    modport slave (
        input  en,
        input  w,
        input  a,
        input  b,
        input  c,
        output d,
        output d_valid
    );
endinterface

// File: rtl/decoder_4x16.sv
// 4-to-16 chip/row-select decoder built from two 3-to-8 halves steered by w,
// with optional output register and selectable output polarity.
module decoder_4x16 #(
    parameter bit REGISTERED = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decoder_4x16_if.slave bus
);

    localparam logic [15:0] D_INACTIVE = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    function automatic logic [7:0] dec_3to8(input logic enable, input logic [2:0] sel);
        logic [7:0] lines;
        lines = 8'h00;
        if (enable) begin
            lines[sel] = 1'b1;
        end else begin
            lines = 8'h00;
        end
        return lines;
    endfunction

    logic [2:0]  sel_s;
    logic        lo_en_s;
    logic        hi_en_s;
    logic [15:0] onehot_s;
    logic [15:0] d_next_s;

    // Split the enable by w so at most one half can ever drive a line.
    always_comb begin
        sel_s    = {bus.a, bus.b, bus.c};
        lo_en_s  = bus.en & ~bus.w;
        hi_en_s  = bus.en & bus.w;
        onehot_s = {dec_3to8(hi_en_s, sel_s), dec_3to8(lo_en_s, sel_s)};
        if (ACTIVE_LOW) begin
            d_next_s = ~onehot_s;
        end else begin
            d_next_s = onehot_s;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [15:0] d_r;
            logic        d_valid_r;

            // Output register; reset wins over any decode on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_r       <= D_INACTIVE;
                    d_valid_r <= 1'b0;
                end else begin
                    d_r       <= d_next_s;
                    d_valid_r <= bus.en;
                end
            end

            assign bus.d       = d_r;
            assign bus.d_valid = d_valid_r;
        end else begin : g_comb
            logic unused_s;
            assign unused_s    = clk ^ rst;
            assign bus.d       = d_next_s;
            assign bus.d_valid = bus.en;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_4x16.sv
// Self-checking bench: registered active-high, registered active-low and
// combinational decoders driven in parallel and compared to a plain model.
module tb_decoder_4x16;

    logic clk;
    logic rst_t;
    logic en_t;
    logic w_t, a_t, b_t, c_t;

    int total;
    int bad;

    decoder_4x16_if if_r ();
    decoder_4x16_if if_l ();
    decoder_4x16_if if_c ();

    assign {if_r.en, if_r.w, if_r.a, if_r.b, if_r.c} = {en_t, w_t, a_t, b_t, c_t};
    assign {if_l.en, if_l.w, if_l.a, if_l.b, if_l.c} = {en_t, w_t, a_t, b_t, c_t};
    assign {if_c.en, if_c.w, if_c.a, if_c.b, if_c.c} = {en_t, w_t, a_t, b_t, c_t};

    decoder_4x16 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) dut_r (.clk(clk), .rst(rst_t), .bus(if_r.slave));
    decoder_4x16 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst(rst_t), .bus(if_l.slave));
    decoder_4x16 #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) dut_c (.clk(clk), .rst(rst_t), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: line idx is raised by shifting a single 1 into place.
    function automatic logic [15:0] model_d(input bit r, input bit e, input int idx, input bit al);
        logic [15:0] v;
        v = (r || !e) ? 16'h0000 : (16'h0001 << idx);
        return al ? ~v : v;
    endfunction

    task automatic drive(input bit r, input bit e, input int idx);
        logic [3:0] sel;
        @(negedge clk);
        sel   = idx[3:0];
        rst_t = r;
        en_t  = e;
        {w_t, a_t, b_t, c_t} = sel;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 5);
            tick();
            total++;
            if (if_r.d !== 16'h0000 || if_r.d_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got d=%h v=%b want d=0000 v=0", if_r.d, if_r.d_valid);
            end
            total++;
            if (if_l.d !== 16'hFFFF || if_l.d_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_active_low: got d=%h v=%b want d=ffff v=0", if_l.d, if_l.d_valid);
            end
        end
        drive(1'b0, 1'b1, 5);
        tick();
        total++;
        if (if_r.d !== 16'h0020 || if_r.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got d=%h v=%b want d=0020 v=1", if_r.d, if_r.d_valid);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, i);
            tick();
            total++;
            if (if_r.d !== model_d(1'b0, 1'b1, i, 1'b0) || if_r.d_valid !== 1'b1 || $countones(if_r.d) != 1) begin
                bad++;
                $display("FAIL sweep idx=%0d: got d=%h v=%b want d=%h v=1", i, if_r.d, if_r.d_valid,
                         model_d(1'b0, 1'b1, i, 1'b0));
            end
        end
    endtask

    task automatic test_enable();
        bit ens [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] want [3] = '{16'h1000, 16'h0000, 16'h1000};
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, ens[k], 12);
            tick();
            total++;
            if (if_r.d !== want[k] || if_r.d_valid !== ens[k]) begin
                bad++;
                $display("FAIL enable step=%0d: got d=%h v=%b want d=%h v=%b", k, if_r.d, if_r.d_valid, want[k], ens[k]);
            end
        end
    endtask

    task automatic test_reset_collision();
        drive(1'b0, 1'b1, 3);
        tick();
        drive(1'b1, 1'b1, 9);
        tick();
        total++;
        if (if_r.d !== 16'h0000 || if_r.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL collision_reset: got d=%h v=%b want d=0000 v=0", if_r.d, if_r.d_valid);
        end
        drive(1'b0, 1'b1, 9);
        tick();
        total++;
        if (if_r.d !== 16'h0200) begin
            bad++;
            $display("FAIL collision_release: got d=%h want d=0200", if_r.d);
        end
    endtask

    task automatic test_active_low();
        drive(1'b0, 1'b1, 0);
        tick();
        total++;
        if (if_l.d !== 16'hFFFE || if_l.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL active_low_idx0: got d=%h v=%b want d=fffe v=1", if_l.d, if_l.d_valid);
        end
        drive(1'b0, 1'b0, 0);
        tick();
        total++;
        if (if_l.d !== 16'hFFFF || if_l.d_valid !== 1'b0) begin
            bad++;
            $display("FAIL active_low_off: got d=%h v=%b want d=ffff v=0", if_l.d, if_l.d_valid);
        end
    endtask

    task automatic test_comb();
        drive(1'b0, 1'b1, 7);
        total++;
        if (if_c.d !== 16'h0080 || if_c.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL comb_idx7: got d=%h v=%b want d=0080 v=1", if_c.d, if_c.d_valid);
        end
        rst_t = 1'b1;
        {w_t, a_t, b_t, c_t} = 4'd8;
        #1;
        total++;
        if (if_c.d !== 16'h0100 || if_c.d_valid !== 1'b1) begin
            bad++;
            $display("FAIL comb_idx8_rst: got d=%h v=%b want d=0100 v=1", if_c.d, if_c.d_valid);
        end
    endtask

    task automatic test_random();
        bit r, e;
        int idx;
        for (int k = 0; k < 60; k++) begin
            r   = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, 15);
            drive(r, e, idx);
            total++;
            if (if_c.d !== model_d(1'b0, e, idx, 1'b0) || if_c.d_valid !== e) begin
                bad++;
                $display("FAIL random_comb k=%0d: got d=%h v=%b want d=%h v=%b", k, if_c.d, if_c.d_valid,
                         model_d(1'b0, e, idx, 1'b0), e);
            end
            tick();
            total++;
            if (if_r.d !== model_d(r, e, idx, 1'b0) || if_r.d_valid !== (e && !r)) begin
                bad++;
                $display("FAIL random_reg k=%0d: got d=%h v=%b want d=%h v=%b", k, if_r.d, if_r.d_valid,
                         model_d(r, e, idx, 1'b0), e && !r);
            end
            total++;
            if (if_l.d !== model_d(r, e, idx, 1'b1) || if_l.d_valid !== (e && !r)) begin
                bad++;
                $display("FAIL random_low k=%0d: got d=%h v=%b want d=%h v=%b", k, if_l.d, if_l.d_valid,
                         model_d(r, e, idx, 1'b1), e && !r);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_t = 1'b1;
        en_t  = 1'b0;
        {w_t, a_t, b_t, c_t} = 4'd0;
        test_reset();
        test_sweep();
        test_enable();
        test_reset_collision();
        test_active_low();
        test_comb();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
